ahb_burst_master: RTL and testbench

AHB-Lite burst initiator: accepts a transfer command and executes it as a pipelined AHB burst. It sources write data from a local synchronous FIFO and sinks read data into another. It is the initiator counterpart to the AHB-slave FIFO wrapper (`cme_ip_fifo_ahb_v2`), and replaces the simulation BFM so on-chip logic can drive the FIFO over the same AHB port.

---
 rtl/ahb_burst_master.sv | 220 ++++++++++++++++++++++
 tb/tb_ahb_burst_master.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_burst_master.sv
// AHB-Lite burst initiator: executes one command as a pipelined burst, sourcing
// write data from a local FIFO and sinking read data into another. Define
// AHB_MST_WRAP_EN to execute WRAP4/8/16 with wrapping addresses.
module ahb_burst_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [2:0]            cmd_burst,
  input  logic [4:0]            cmd_len,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [1:0]            htrans,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic [2:0]            hburst,
  output logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  input  logic                  hresp,
  input  logic [DATA_WIDTH-1:0] hrdata,
  output logic                  src_ren,
  input  logic [DATA_WIDTH-1:0] src_rdata,
  input  logic                  src_rempty,
  output logic                  snk_wen,
  output logic [DATA_WIDTH-1:0] snk_wdata,
  input  logic                  snk_wfull,
  input  logic                  snk_almost_full
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_BEAT,
    S_LAST,
    S_ERR
  } state_e;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
  logic [1:0]            htrans_q, htrans_d;
  logic                  hwrite_q, hwrite_d;
  logic [2:0]            hburst_q, hburst_d;
  logic [4:0]            beats_q, beats_d;
  logic                  dphase_q, dphase_d;
  logic                  dwrite_q, dwrite_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [ADDR_WIDTH-1:0] addr_inc, addr_next;
  logic [2:0]            burst_eff;
  logic                  wr_ok, rd_ok, rd_outstanding, go_ok, beat_ok, data_err;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^cmd_addr[1:0];

  function automatic logic [4:0] burst_beats(input logic [2:0] code, input logic [4:0] len);
    case (code)
      3'd0:       return 5'd1;
      3'd1:       return (len == 5'd0) ? 5'd1 : len;
      3'd2, 3'd3: return 5'd4;
      3'd4, 3'd5: return 5'd8;
      default:    return 5'd16;
    endcase
  endfunction

  assign addr_inc = haddr_q + ADDR_WIDTH'(4);

`ifdef AHB_MST_WRAP_EN
  logic [ADDR_WIDTH-1:0] wrap_mask;

  assign burst_eff = cmd_burst;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wrap_mask = '0;
    case (hburst_q)
      3'd2:    wrap_mask = ADDR_WIDTH'(32'h0F);
      3'd4:    wrap_mask = ADDR_WIDTH'(32'h1F);
      3'd6:    wrap_mask = ADDR_WIDTH'(32'h3F);
      default: wrap_mask = '0;
    endcase
    addr_next = (wrap_mask == '0) ? addr_inc
                                  : ((haddr_q & ~wrap_mask) | (addr_inc & wrap_mask));
  end
`else
  // Wrap codes become the same-length INCR code; addresses stay linear.
  assign burst_eff = (cmd_burst != 3'd0 && !cmd_burst[0]) ? (cmd_burst | 3'd1) : cmd_burst;
  assign addr_next = addr_inc;
`endif

  // A read address phase in flight also counts, since its push precedes ours.
  assign rd_outstanding = (dphase_q & ~dwrite_q) | (htrans_q[1] & ~hwrite_q);
  assign wr_ok    = ~src_rempty;
  assign rd_ok    = ~snk_wfull & ~(snk_almost_full & rd_outstanding);
  assign go_ok    = cmd_write ? wr_ok : rd_ok;
  assign beat_ok  = hwrite_q ? wr_ok : rd_ok;
  assign data_err = dphase_q & hresp & ~hready;

  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    htrans_d = htrans_q;
    hwrite_d = hwrite_q;
    hburst_d = hburst_q;
    beats_d  = beats_q;
    dphase_d = dphase_q;
    dwrite_d = dwrite_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    if (hready) begin
      dphase_d = htrans_q[1];
      dwrite_d = hwrite_q;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          hwrite_d = cmd_write;
          hburst_d = burst_eff;
          haddr_d  = {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
          beats_d  = burst_beats(cmd_burst, cmd_len) - 5'd1;
          htrans_d = go_ok ? HT_NONSEQ : HT_IDLE;
          state_d  = S_ADDR;
        end
      end
      S_ADDR, S_BEAT: begin
        if (hready) begin
          if (htrans_q[1]) begin
            if (beats_q == 5'd0) begin
              htrans_d = HT_IDLE;
              state_d  = S_LAST;
            end else begin
              haddr_d  = addr_next;
              beats_d  = beats_q - 5'd1;
              state_d  = S_BEAT;
              // The final beat may not be BUSY, so it is issued without waiting.
              htrans_d = (beat_ok || beats_q == 5'd1) ? HT_SEQ : HT_BUSY;
            end
          end else if (state_q == S_ADDR) begin
            htrans_d = beat_ok ? HT_NONSEQ : HT_IDLE;
          end else begin
            htrans_d = beat_ok ? HT_SEQ : HT_BUSY;
          end
        end
      end
      S_LAST: begin
        if (hready) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_ERR: begin
        htrans_d = HT_IDLE;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // First ERROR cycle: cancel the pending address phase and abort.
    if (data_err) begin
      state_d  = S_ERR;
      htrans_d = HT_IDLE;
      err_d    = 1'b1;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= S_IDLE;
      haddr_q  <= '0;
      htrans_q <= HT_IDLE;
      hwrite_q <= 1'b0;
      hburst_q <= 3'd0;
      beats_q  <= 5'd0;
      dphase_q <= 1'b0;
      dwrite_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      htrans_q <= htrans_d;
      hwrite_q <= hwrite_d;
      hburst_q <= hburst_d;
      beats_q  <= beats_d;
      dphase_q <= dphase_d;
      dwrite_q <= dwrite_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign haddr     = haddr_q;
  assign htrans    = htrans_q;
  assign hwrite    = hwrite_q;
  assign hsize     = 3'b010;
  assign hburst    = hburst_q;
  assign hwdata    = src_rdata;
  assign src_ren   = htrans_q[1] & hwrite_q & hready;
  assign snk_wen   = dphase_q & ~dwrite_q & hready & ~hresp;
  assign snk_wdata = hrdata;

endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed bench for ahb_burst_master: behavioural source/sink FIFOs and a
// hand-driven AHB slave; expected values are written out per cycle.
module tb_ahb_burst_master;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [2:0]  cmd_burst = '0;
  logic [4:0]  cmd_len = '0;
  logic        done, err;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [31:0] hwdata;
  logic        hready = 1'b1;
  logic        hresp = 1'b0;
  logic [31:0] hrdata = '0;
  logic        src_ren;
  logic [31:0] src_rdata = 32'hCAFE_F00D;
  logic        src_rempty = 1'b0;
  logic        snk_wen;
  logic [31:0] snk_wdata;
  logic        snk_wfull = 1'b0;
  logic        snk_almost_full = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int push_cnt = 0;
  int pop_base, push_base;
  logic [31:0] wrap_exp [8];
  logic [2:0]  wrap_hburst;

  ahb_burst_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_burst(cmd_burst), .cmd_len(cmd_len),
    .done(done), .err(err),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hwdata(hwdata),
    .hready(hready), .hresp(hresp), .hrdata(hrdata),
    .src_ren(src_ren), .src_rdata(src_rdata), .src_rempty(src_rempty),
    .snk_wen(snk_wen), .snk_wdata(snk_wdata), .snk_wfull(snk_wfull),
    .snk_almost_full(snk_almost_full)
  );

  always #5 hclk = ~hclk;

  // Source FIFO: entry i holds (i+1)*0x11, visible the cycle after its pop.
  always @(posedge hclk) begin
    if (src_ren) begin
      src_rdata <= 32'((pop_cnt + 1) * 32'h11);
      pop_cnt   <= pop_cnt + 1;
    end
  end

  always @(posedge hclk) begin
    if (snk_wen) push_cnt <= push_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
    cyc++;
    hrdata = 32'hD000_0000 | 32'(cyc);
    #1;
  endtask

  // Presents a command, checks it is offered in IDLE, and returns in cycle 1.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] burst,
                       input logic [4:0] len);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_burst = burst;
    cmd_len   = len;
    #1;
    check("cmd_ready_idle", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
`ifdef AHB_MST_WRAP_EN
    wrap_exp[0] = 32'hA000_0018; wrap_exp[1] = 32'hA000_001C;
    wrap_exp[2] = 32'hA000_0000; wrap_exp[3] = 32'hA000_0004;
    wrap_exp[4] = 32'hA000_0008; wrap_exp[5] = 32'hA000_000C;
    wrap_exp[6] = 32'hA000_0010; wrap_exp[7] = 32'hA000_0014;
    wrap_hburst = 3'd4;
`else
    wrap_exp[0] = 32'hA000_0018; wrap_exp[1] = 32'hA000_001C;
    wrap_exp[2] = 32'hA000_0020; wrap_exp[3] = 32'hA000_0024;
    wrap_exp[4] = 32'hA000_0028; wrap_exp[5] = 32'hA000_002C;
    wrap_exp[6] = 32'hA000_0030; wrap_exp[7] = 32'hA000_0034;
    wrap_hburst = 3'd5;
`endif

    // Reset values
    #2;
    check("rst_htrans", htrans, 0);
    check("rst_haddr", haddr, 0);
    check("rst_hwrite", hwrite, 0);
    check("rst_hburst", hburst, 0);
    check("rst_hsize", hsize, 3'b010);
    check("rst_hwdata", hwdata, 32'hCAFE_F00D);
    check("rst_src_ren", src_ren, 0);
    check("rst_snk_wen", snk_wen, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    repeat (2) @(posedge hclk);
    #2;
    hresetn = 1'b1;

    // Write INCR4 at A000_0000, no waits
    pop_base = pop_cnt;
    issue(1'b1, 32'hA000_0000, 3'd3, 5'd0);
    check("w4_hburst", hburst, 3);
    check("w4_hwrite", hwrite, 1);
    check("w4_src_ren", src_ren, 1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        tick();
        check("w4_hwdata", hwdata, 32'h11 * k);
      end
      check("w4_haddr", haddr, 32'hA000_0000 + 32'(4 * k));
      check("w4_htrans", htrans, (k == 0) ? 2'b10 : 2'b11);
      check("w4_cmd_ready", cmd_ready, 0);
    end
    tick();
    check("w4_last_htrans", htrans, 0);
    check("w4_last_hwdata", hwdata, 32'h44);
    check("w4_last_done", done, 0);
    tick();
    check("w4_done", done, 1);
    check("w4_done_ready", cmd_ready, 1);
    check("w4_pops", pop_cnt - pop_base, 4);
    tick();
    check("w4_done_pulse", done, 0);

    // Read WRAP8 at A000_0018
    push_base = push_cnt;
    issue(1'b0, 32'hA000_0018, 3'd4, 5'd0);
    check("r8_hburst", hburst, wrap_hburst);
    check("r8_first_no_push", snk_wen, 0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        tick();
        check("r8_snk_wen", snk_wen, 1);
      end
      check("r8_haddr", haddr, wrap_exp[k]);
      check("r8_htrans", htrans, (k == 0) ? 2'b10 : 2'b11);
    end
    tick();
    check("r8_last_htrans", htrans, 0);
    check("r8_last_wen", snk_wen, 1);
    check("r8_last_wdata", snk_wdata, 32'hD000_0000 | 32'(cyc));
    tick();
    check("r8_done", done, 1);
    check("r8_pushes", push_cnt - push_base, 8);

    // Write INCR8 with the source empty for two decision cycles after beat 3
    pop_base = pop_cnt;
    issue(1'b1, 32'hA000_0000, 3'd5, 5'd0);
    check("w8_b1", haddr, 32'hA000_0000);
    tick();
    check("w8_b2", haddr, 32'hA000_0004);
    tick();
    check("w8_b3", haddr, 32'hA000_0008);
    check("w8_b3_trans", htrans, 2'b11);
    src_rempty = 1'b1;
    tick();
    check("w8_busy1_trans", htrans, 2'b01);
    check("w8_busy1_addr", haddr, 32'hA000_000C);
    check("w8_busy1_ren", src_ren, 0);
    tick();
    check("w8_busy2_trans", htrans, 2'b01);
    check("w8_busy2_addr", haddr, 32'hA000_000C);
    src_rempty = 1'b0;
    tick();
    check("w8_resume_trans", htrans, 2'b11);
    check("w8_resume_addr", haddr, 32'hA000_000C);
    for (int k = 4; k < 8; k++) begin
      tick();
      if (k == 4) check("w8_b4_hwdata", hwdata, 32'((pop_base + 4) * 32'h11));
      check("w8_haddr", haddr, 32'hA000_0000 + 32'(4 * k));
      check("w8_htrans", htrans, 2'b11);
    end
    tick();
    check("w8_last_htrans", htrans, 0);
    tick();
    check("w8_done", done, 1);
    check("w8_pops", pop_cnt - pop_base, 8);

    // Read INCR16 with hready low for three cycles during beat 2
    push_base = push_cnt;
    issue(1'b0, 32'hA000_0100, 3'd7, 5'd0);
    check("r16_b1", haddr, 32'hA000_0100);
    tick();
    hready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      check("r16_stall_addr", haddr, 32'hA000_0104);
      check("r16_stall_trans", htrans, 2'b11);
      check("r16_stall_wen", snk_wen, 0);
    end
    tick();
    hready = 1'b1;
    #1;
    check("r16_release_addr", haddr, 32'hA000_0104);
    check("r16_release_wen", snk_wen, 1);
    for (int k = 2; k < 16; k++) begin
      tick();
      check("r16_haddr", haddr, 32'hA000_0100 + 32'(4 * k));
    end
    tick();
    check("r16_last_htrans", htrans, 0);
    check("r16_last_done", done, 0);
    tick();
    check("r16_done", done, 1);
    check("r16_pushes", push_cnt - push_base, 16);

    // Write INCR16 with an ERROR response in beat 3's data phase
    pop_base = pop_cnt;
    issue(1'b1, 32'hA000_0200, 3'd7, 5'd0);
    tick();
    tick();
    check("we_b3", haddr, 32'hA000_0208);
    tick();
    hready = 1'b0;
    hresp  = 1'b1;
    #1;
    check("we_err1_addr", haddr, 32'hA000_020C);
    check("we_err1_ren", src_ren, 0);
    check("we_err1_hwdata", hwdata, 32'((pop_base + 3) * 32'h11));
    check("we_err1_err", err, 0);
    tick();
    hready = 1'b1;
    #1;
    check("we_err2_htrans", htrans, 0);
    check("we_err2_err", err, 1);
    check("we_err2_ready", cmd_ready, 0);
    check("we_err2_ren", src_ren, 0);
    tick();
    hresp = 1'b0;
    #1;
    check("we_ready", cmd_ready, 1);
    check("we_err_pulse", err, 0);
    check("we_no_done", done, 0);
    check("we_pops", pop_cnt - pop_base, 3);

    // Reset mid-burst, then a one-beat INCR read
    issue(1'b1, 32'hB000_0010, 3'd1, 5'd3);
    check("rs_b1_trans", htrans, 2'b10);
    check("rs_b1_hburst", hburst, 1);
    tick();
    check("rs_b2_addr", haddr, 32'hB000_0014);
    hresetn = 1'b0;
    #1;
    check("rs_htrans", htrans, 0);
    check("rs_haddr", haddr, 0);
    check("rs_hwrite", hwrite, 0);
    check("rs_hburst", hburst, 0);
    check("rs_src_ren", src_ren, 0);
    check("rs_cmd_ready", cmd_ready, 1);
    check("rs_hwdata", hwdata, src_rdata);
    tick();
    tick();
    hresetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rs_no_done", done, 0);
    end
    push_base = push_cnt;
    issue(1'b0, 32'hC000_0007, 3'd1, 5'd0);
    check("r1_haddr", haddr, 32'hC000_0004);
    check("r1_htrans", htrans, 2'b10);
    check("r1_hburst", hburst, 1);
    check("r1_hwrite", hwrite, 0);
    tick();
    check("r1_last_htrans", htrans, 0);
    check("r1_snk_wen", snk_wen, 1);
    tick();
    check("r1_done", done, 1);
    check("r1_ready", cmd_ready, 1);
    check("r1_pushes", push_cnt - push_base, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
